// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg
// Shared definitions for the round-robin capable priority arbiter.
//   MODE_FIXED / MODE_RR : encodings of the mode_rr input
//   MAX_N                : widest request vector the arbiter supports
//   onehot_of(idx, n)    : one-hot vector with bit idx set, or zero when
//                          idx is not a legal position for an n-wide vector
package prio_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_N = 64;

  // Callers truncate the result to their own width with a size cast.
  function automatic logic [MAX_N-1:0] onehot_of(input int unsigned idx,
                                                 input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_N) begin
      v[idx] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// prio_arbiter_rr_if
// Request/grant bundle between request sources and the arbiter.
//   en      : evaluate enable (0 = arbiter holds all state)
//   mode_rr : 0 = fixed priority, 1 = round-robin
//   hold    : keep the current grant while its request stays asserted
//   req     : request vector, bit i = requester i
//   idx     : binary index of the current winner
//   gnt     : one-hot grant
//   valid   : some request won the last evaluation
// The master modport is the requester side, slave is the arbiter side.
interface prio_arbiter_rr_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic          en;
  logic          mode_rr;
  logic          hold;
  logic [N-1:0]  req;
  logic [IW-1:0] idx;
  logic [N-1:0]  gnt;
  logic          valid;

  modport master (
    output en, mode_rr, hold, req,
    input  idx, gnt, valid
  );

  modport slave (
    input  en, mode_rr, hold, req,
    output idx, gnt, valid
  );

endinterface

// File: rtl/prio_find_first.sv
// prio_find_first
// Combinational rotated lowest-set-bit search.
//   vec   : candidate vector
//   start : first position to consider; the scan wraps from N-1 to 0
//   found : some bit of vec is set
//   pos   : first set position at or after start (wrapping)
// A start of N or more is treated as 0.
module prio_find_first
  import prio_arb_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] pos
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int             start_i;

  // The vector is duplicated side by side so a wrapped scan becomes a plain
  // lowest-bit search: bits below start are masked in the lower copy only,
  // and hits in the upper copy map back by subtracting N.
  always_comb begin
    start_i = int'(start);
    if (start_i >= N) begin
      start_i = 0;
    end
    dbl = {vec, vec};
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = dbl[j] && (j >= start_i);
    end
    found = 1'b0;
    pos   = '0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        pos   = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr
// Registered N-input priority arbiter with fixed and round-robin modes,
// clock enable and grant hold.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears outputs and the pointer
//   bus : slave side of prio_arbiter_rr_if (en, mode_rr, hold, req in;
//         idx, gnt, valid out)
// All outputs come straight from flops; results appear one cycle after the
// inputs are sampled.
module prio_arbiter_rr
  import prio_arb_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  prio_arbiter_rr_if.slave  bus
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] start;
  logic [IW-1:0] pos;
  logic          found;
  logic          locked;

  // Fixed priority is just the rotated search starting at bit 0.
  assign start = (bus.mode_rr == MODE_RR) ? ptr_q : '0;

  prio_find_first #(.N(N)) u_find (
    .vec   (bus.req),
    .start (start),
    .found (found),
    .pos   (pos)
  );

  // The lock only applies while the previously granted line is still
  // requesting; once it drops, arbitration resumes in the same evaluation.
  assign locked = bus.hold && valid_q && bus.req[idx_q];

  // Next-state: everything holds unless enabled and not locked.
  always_comb begin
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (bus.en && !locked) begin
      if (!found) begin
        idx_d   = '0;
        gnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d   = pos;
        gnt_d   = N'(onehot_of(int'(pos), N));
        valid_d = 1'b1;
        if (bus.mode_rr == MODE_RR) begin
          ptr_d = (pos == LAST) ? '0 : pos + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.idx   = idx_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb_prio_arbiter_rr
// Self-checking bench for prio_arbiter_rr. Two instances (N=4 and N=5) share
// clock and reset. A behavioural model tracks both and is compared against
// every output every cycle; directed sequences add literal expectations.
module tb_prio_arbiter_rr;
  import prio_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  prio_arbiter_rr_if #(.N(4)) bus4();
  prio_arbiter_rr_if #(.N(5)) bus5();

  prio_arbiter_rr #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  prio_arbiter_rr #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  always #5 clk = ~clk;

  // Model state, index 0 = N=4 instance, index 1 = N=5 instance.
  int m_idx[2];
  bit m_valid[2];
  int m_ptr[2];
  bit armed = 1'b0;

  task automatic checkVal(input string name, input logic [7:0] got,
                          input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // First set requester scanning start, start+1, ... modulo n; -1 if none.
  function automatic int pick(input int n, input logic [7:0] r, input int start);
    int s;
    int b;
    s = (start >= n) ? 0 : start;
    for (int k = 0; k < n; k++) begin
      b = (s + k) % n;
      if (r[b]) return b;
    end
    return -1;
  endfunction

  task automatic modelStep(input int d, input int n, input logic [7:0] r,
                           input logic e, input logic rr, input logic h);
    int w;
    if (!e) return;
    if (h && m_valid[d] && r[m_idx[d]]) return;
    w = pick(n, r, rr ? m_ptr[d] : 0);
    if (w < 0) begin
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
    end else begin
      m_valid[d] = 1'b1;
      m_idx[d]   = w;
      if (rr) m_ptr[d] = (w + 1) % n;
    end
  endtask

  function automatic logic [7:0] expGnt(input int d);
    return m_valid[d] ? 8'(1 << m_idx[d]) : 8'h00;
  endfunction

  // Compare process: advance the model on each edge, check #1 later.
  always begin
    @(posedge clk);
    if (rst) begin
      armed = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_idx[d] = 0; m_valid[d] = 1'b0; m_ptr[d] = 0;
      end
    end else if (armed) begin
      modelStep(0, 4, 8'(bus4.req), bus4.en, bus4.mode_rr, bus4.hold);
      modelStep(1, 5, 8'(bus5.req), bus5.en, bus5.mode_rr, bus5.hold);
    end
    #1;
    if (armed) begin
      checkVal("model4_idx",   8'(bus4.idx),   8'(m_idx[0]));
      checkVal("model4_valid", 8'(bus4.valid), 8'(m_valid[0]));
      checkVal("model4_gnt",   8'(bus4.gnt),   expGnt(0));
      checkVal("model5_idx",   8'(bus5.idx),   8'(m_idx[1]));
      checkVal("model5_valid", 8'(bus5.valid), 8'(m_valid[1]));
      checkVal("model5_gnt",   8'(bus5.gnt),   expGnt(1));
    end
  end

  // Drive one instance's inputs and advance one clock.
  task automatic applyStimulus(input int d, input logic [7:0] r, input logic e,
                               input logic rr, input logic h);
    if (d == 0) begin
      bus4.req = r[3:0]; bus4.en = e; bus4.mode_rr = rr; bus4.hold = h;
    end else begin
      bus5.req = r[4:0]; bus5.en = e; bus5.mode_rr = rr; bus5.hold = h;
    end
    @(posedge clk);
    #2;
  endtask

  // Literal expectation for one instance's outputs.
  task automatic checkOutput(input string name, input int d, input logic v,
                             input int i);
    logic [7:0] g;
    g = v ? 8'(1 << i) : 8'h00;
    if (d == 0) begin
      checkVal({name, "_valid"}, 8'(bus4.valid), 8'(v));
      checkVal({name, "_idx"},   8'(bus4.idx),   8'(i));
      checkVal({name, "_gnt"},   8'(bus4.gnt),   g);
    end else begin
      checkVal({name, "_valid"}, 8'(bus5.valid), 8'(v));
      checkVal({name, "_idx"},   8'(bus5.idx),   8'(i));
      checkVal({name, "_gnt"},   8'(bus5.gnt),   g);
    end
  endtask

  int lowest[16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
  int rr_all[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
  int rr_two[4]  = '{1, 4, 1, 4};
  int valid_cnt;

  initial begin
    rst = 1'b1;
    bus4.req = '0; bus4.en = 1'b1; bus4.mode_rr = MODE_FIXED; bus4.hold = 1'b0;
    bus5.req = '0; bus5.en = 1'b1; bus5.mode_rr = MODE_FIXED; bus5.hold = 1'b0;

    // Reset wins over a full request vector, then idle.
    applyStimulus(0, 8'h0F, 1'b1, 1'b0, 1'b0);
    checkOutput("reset", 0, 1'b0, 0);
    rst = 1'b0;
    applyStimulus(0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("idle", 0, 1'b0, 0);

    // Fixed-priority sweep over every 4-bit request pattern.
    valid_cnt = 0;
    for (int r = 0; r < 16; r++) begin
      applyStimulus(0, 8'(r), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("fixed_req%0d", r), 0, (r != 0), lowest[r]);
      if (bus4.valid === 1'b1) valid_cnt++;
    end
    checkVal("fixed_valid_count", 8'(valid_cnt), 8'd15);

    // Round-robin fairness on N=5, including the 4->0 wrap.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 8'h1F, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("rr_all%0d", k), 1, 1'b1, rr_all[k]);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'h12, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("rr_two%0d", k), 1, 1'b1, rr_two[k]);
    end

    // Hold lock on N=4: grant 2, keep it while req[2] stays high.
    applyStimulus(0, 8'h04, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_grant", 0, 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 8'h0F, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("hold_lock%0d", k), 0, 1'b1, 2);
    end
    applyStimulus(0, 8'h0B, 1'b1, 1'b1, 1'b1);
    checkOutput("hold_release", 0, 1'b1, 3);

    // Enable low: outputs frozen while requests change.
    applyStimulus(0, 8'h01, 1'b0, 1'b1, 1'b0);
    checkOutput("en_off0", 0, 1'b1, 3);
    applyStimulus(0, 8'h06, 1'b0, 1'b0, 1'b0);
    checkOutput("en_off1", 0, 1'b1, 3);
    applyStimulus(0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("en_off2", 0, 1'b1, 3);

    // Mode switch with ptr=3: fixed picks 0, back to RR picks 3.
    applyStimulus(0, 8'h04, 1'b1, 1'b1, 1'b0);
    checkOutput("mode_setup", 0, 1'b1, 2);
    applyStimulus(0, 8'h09, 1'b1, 1'b0, 1'b0);
    checkOutput("mode_fixed", 0, 1'b1, 0);
    applyStimulus(0, 8'h09, 1'b1, 1'b1, 1'b0);
    checkOutput("mode_rr", 0, 1'b1, 3);

    // Reset mid-operation on N=5 with ptr=3.
    applyStimulus(1, 8'h04, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_setup", 1, 1'b1, 2);
    rst = 1'b1;
    applyStimulus(1, 8'h1F, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_reset", 1, 1'b0, 0);
    rst = 1'b0;
    applyStimulus(1, 8'h1F, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_first", 1, 1'b1, 0);
    applyStimulus(1, 8'h1F, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_second", 1, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
